// File: rtl/ivs_pend_sched.sv
// Round-robin pending-request scheduler.
// Sticky request bits collect in a 32-bit pending vector. One pending index
// at a time is offered on a valid/ready handshake, and the bit is retired
// when the offer is accepted. The search for the next index starts just
// above the last granted index.
module ivs_pend_sched #(
  parameter int NUM   = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             set_vld,
  input  logic [NUM-1:0]   set_vec,
  output logic             sel_vld,
  output logic [IDX_W-1:0] sel_idx,
  input  logic             sel_rdy,
  output logic [NUM-1:0]   pend_vec,
  output logic [IDX_W:0]   pend_cnt,
  output logic             dup_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [NUM-1:0]   pend, pend_next;
  logic [NUM-1:0]   acc_mask, set_mask, rot;
  logic [2*NUM-1:0] dbl;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic [IDX_W-1:0] idx_q, idx_next;
  logic [IDX_W-1:0] k, cand;
  logic [IDX_W:0]   cnt_q, cnt_next;
  logic             dup_q, dup_next;
  logic             accept;

  // Retire mask for the accepted offer and the qualified set bits.
  always_comb begin
    accept   = (state == OFFER) && sel_rdy;
    acc_mask = accept ? (NUM'(1) << idx_q) : '0;
    set_mask = set_vld ? set_vec : '0;
  end

  // Next pending vector and duplicate detection; a flush discards everything.
  always_comb begin
    pend_next = (pend & ~acc_mask) | set_mask;
    dup_next  = |(set_mask & pend & ~acc_mask);
    if (clr) begin
      pend_next = '0;
      dup_next  = 1'b0;
    end
  end

  // Popcount of the next pending vector so the count tracks pend_vec exactly.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NUM; i++) begin
      cnt_next = cnt_next + {{IDX_W{1'b0}}, pend_next[i]};
    end
  end

  // Round-robin pick: rotate registered pend by ptr, find lowest set bit.
  always_comb begin
    dbl = {pend, pend} >> ptr;
    rot = dbl[NUM-1:0];
    k   = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (rot[i]) begin
        k = IDX_W'(i);
      end
    end
    cand = k + ptr;
  end

  // Offer state machine: latch a candidate in IDLE, hold it in OFFER until taken.
  always_comb begin
    state_next = state;
    idx_next   = idx_q;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (|pend) begin
          idx_next   = cand;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (sel_rdy) begin
          ptr_next   = idx_q + IDX_W'(1);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (clr) begin
      state_next = IDLE;
      ptr_next   = '0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      ptr   <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      dup_q <= 1'b0;
    end else begin
      state <= state_next;
      pend  <= pend_next;
      ptr   <= ptr_next;
      idx_q <= idx_next;
      cnt_q <= cnt_next;
      dup_q <= dup_next;
    end
  end

  assign sel_vld  = (state == OFFER);
  assign sel_idx  = idx_q;
  assign pend_vec = pend;
  assign pend_cnt = cnt_q;
  assign dup_err  = dup_q;

endmodule

// File: tb/tb_ivs_pend_sched.sv
// Self-checking bench for ivs_pend_sched: directed scenarios plus a
// randomized run compared against a behavioural model of the scheduler.
module tb_ivs_pend_sched;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        set_vld;
  logic [31:0] set_vec;
  logic        sel_vld;
  logic [4:0]  sel_idx;
  logic        sel_rdy;
  logic [31:0] pend_vec;
  logic [5:0]  pend_cnt;
  logic        dup_err;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_pend;
  int          m_ptr;
  bit          m_off;
  int          m_idx;
  bit          m_dup;
  int          m_cnt;

  ivs_pend_sched #(.NUM(32), .IDX_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .set_vld  (set_vld),
    .set_vec  (set_vec),
    .sel_vld  (sel_vld),
    .sel_idx  (sel_idx),
    .sel_rdy  (sel_rdy),
    .pend_vec (pend_vec),
    .pend_cnt (pend_cnt),
    .dup_err  (dup_err)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one clock edge of the scheduler described by its rules
  task automatic model_step();
    logic [31:0] kept;
    logic [31:0] added;
    if (!rst_n) begin
      m_pend = '0; m_ptr = 0; m_off = 0; m_idx = 0; m_dup = 0;
    end else if (clr) begin
      m_pend = '0; m_ptr = 0; m_off = 0; m_dup = 0;
    end else begin
      kept = m_pend;
      if (m_off && sel_rdy) kept[m_idx] = 1'b0;
      added = set_vld ? set_vec : 32'h0;
      m_dup = (added & kept) != 0;
      if (m_off) begin
        if (sel_rdy) begin
          m_ptr = (m_idx + 1) % 32;
          m_off = 0;
        end
      end else if (m_pend != 0) begin
        for (int i = 0; i < 32; i++) begin
          if (m_pend[(m_ptr + i) % 32]) begin
            m_idx = (m_ptr + i) % 32;
            break;
          end
        end
        m_off = 1;
      end
      m_pend = kept | added;
    end
    m_cnt = 0;
    for (int i = 0; i < 32; i++) m_cnt += int'(m_pend[i]);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle
  task automatic tick(input logic sv, input logic [31:0] vec, input logic rdy,
                      input logic c, input logic rn = 1'b1);
    set_vld = sv;
    set_vec = vec;
    sel_rdy = rdy;
    clr     = c;
    rst_n   = rn;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Idle with sel_rdy=0 until an offer appears (bounded), returning its index
  task automatic wait_offer(output logic [4:0] idx, output bit ok);
    ok  = 0;
    idx = '0;
    for (int i = 0; i < 10; i++) begin
      if (sel_vld === 1'b1) begin
        ok  = 1;
        idx = sel_idx;
        break;
      end
      tick(1'b0, 32'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({sel_vld, sel_idx, pend_vec, pend_cnt, dup_err} !== 45'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got vld=%0b idx=%0d pend=%h cnt=%0d dup=%0b, want all 0",
               sel_vld, sel_idx, pend_vec, pend_cnt, dup_err);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if ({sel_vld, pend_vec, pend_cnt, dup_err} !== 40'h0) begin
        errors++;
        $display("[TB] FAIL idle_quiet cycle %0d: got vld=%0b pend=%h cnt=%0d dup=%0b, want all 0",
                 i, sel_vld, pend_vec, pend_cnt, dup_err);
      end
    end
  endtask

  task automatic test_two_bits();
    tick(1'b1, 32'h0000_0011, 1'b1, 1'b0);
    checks++;
    if (sel_vld !== 1'b0 || pend_vec !== 32'h11 || pend_cnt !== 6'd2) begin
      errors++;
      $display("[TB] FAIL two_bits_t1: got vld=%0b pend=%h cnt=%0d, want vld=0 pend=11 cnt=2",
               sel_vld, pend_vec, pend_cnt);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (sel_vld !== 1'b1 || sel_idx !== 5'd0) begin
      errors++;
      $display("[TB] FAIL two_bits_t2: got vld=%0b idx=%0d, want vld=1 idx=0", sel_vld, sel_idx);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (sel_vld !== 1'b0 || pend_vec !== 32'h10) begin
      errors++;
      $display("[TB] FAIL two_bits_t3: got vld=%0b pend=%h, want vld=0 pend=10", sel_vld, pend_vec);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (sel_vld !== 1'b1 || sel_idx !== 5'd4) begin
      errors++;
      $display("[TB] FAIL two_bits_t4: got vld=%0b idx=%0d, want vld=1 idx=4", sel_vld, sel_idx);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (sel_vld !== 1'b0 || pend_vec !== 32'h0 || pend_cnt !== 6'd0) begin
      errors++;
      $display("[TB] FAIL two_bits_t5: got vld=%0b pend=%h cnt=%0d, want vld=0 pend=0 cnt=0",
               sel_vld, pend_vec, pend_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] idx;
    bit         ok;
    int         exp_seq[5] = '{29, 31, 1, 3, 1};
    logic [31:0] set_seq[5] = '{32'h2000_0000, 32'h8000_0002, 32'h0, 32'h0000_000A, 32'h0};
    for (int g = 0; g < 5; g++) begin
      if (set_seq[g] != 32'h0) tick(1'b1, set_seq[g], 1'b0, 1'b0);
      wait_offer(idx, ok);
      checks++;
      if (!ok || idx !== 5'(exp_seq[g])) begin
        errors++;
        $display("[TB] FAIL wrap_grant %0d: got ok=%0b idx=%0d, want ok=1 idx=%0d", g, ok, idx, exp_seq[g]);
      end
      tick(1'b0, 32'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] idx;
    bit         ok;
    tick(1'b1, 32'h0000_0080, 1'b0, 1'b0);
    wait_offer(idx, ok);
    checks++;
    if (!ok || idx !== 5'd7) begin
      errors++;
      $display("[TB] FAIL bp_first_offer: got ok=%0b idx=%0d, want ok=1 idx=7", ok, idx);
    end
    for (int i = 0; i < 20; i++) begin
      tick(i == 0, 32'h1, 1'b0, 1'b0);
      checks++;
      if (sel_vld !== 1'b1 || sel_idx !== 5'd7) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d: got vld=%0b idx=%0d, want vld=1 idx=7", i, sel_vld, sel_idx);
      end
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    wait_offer(idx, ok);
    checks++;
    if (!ok || idx !== 5'd0) begin
      errors++;
      $display("[TB] FAIL bp_next_grant: got ok=%0b idx=%0d, want ok=1 idx=0", ok, idx);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_collision();
    logic [4:0] idx;
    bit         ok;
    tick(1'b1, 32'h20, 1'b0, 1'b0);
    wait_offer(idx, ok);
    tick(1'b1, 32'h20, 1'b0, 1'b0);
    checks++;
    if (dup_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dup_pulse: got dup=%0b, want 1", dup_err);
    end
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (dup_err !== 1'b0 || sel_vld !== 1'b1 || sel_idx !== 5'd5) begin
      errors++;
      $display("[TB] FAIL dup_one_cycle: got dup=%0b vld=%0b idx=%0d, want dup=0 vld=1 idx=5",
               dup_err, sel_vld, sel_idx);
    end
    tick(1'b1, 32'h20, 1'b1, 1'b0);
    checks++;
    if (dup_err !== 1'b0 || pend_vec !== 32'h20 || sel_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL accept_reset_bit: got dup=%0b pend=%h vld=%0b, want dup=0 pend=20 vld=0",
               dup_err, pend_vec, sel_vld);
    end
    wait_offer(idx, ok);
    checks++;
    if (!ok || idx !== 5'd5) begin
      errors++;
      $display("[TB] FAIL collision_regrant: got ok=%0b idx=%0d, want ok=1 idx=5", ok, idx);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    logic [4:0] idx;
    bit         ok;
    tick(1'b1, 32'h0010_0000, 1'b0, 1'b0);
    wait_offer(idx, ok);
    tick(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    checks++;
    if (sel_vld !== 1'b0 || pend_vec !== 32'h0 || pend_cnt !== 6'd0 || dup_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_state: got vld=%0b pend=%h cnt=%0d dup=%0b, want all 0",
               sel_vld, pend_vec, pend_cnt, dup_err);
    end
    tick(1'b1, 32'h0000_0208, 1'b0, 1'b0);
    wait_offer(idx, ok);
    checks++;
    if (!ok || idx !== 5'd3) begin
      errors++;
      $display("[TB] FAIL flush_first_grant: got ok=%0b idx=%0d, want ok=1 idx=3", ok, idx);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    wait_offer(idx, ok);
    tick(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_all_pending();
    logic [4:0] idx;
    bit         ok;
    int         bad;
    tick(1'b0, 32'h0, 1'b0, 1'b1);
    tick(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if (pend_cnt !== 6'd32 || pend_vec !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL all_count: got cnt=%0d pend=%h, want cnt=32 pend=ffffffff", pend_cnt, pend_vec);
    end
    bad = 0;
    for (int g = 0; g < 32; g++) begin
      wait_offer(idx, ok);
      checks++;
      if (!ok || idx !== 5'(g)) begin
        errors++;
        $display("[TB] FAIL all_rotate %0d: got ok=%0b idx=%0d, want ok=1 idx=%0d", g, ok, idx, g);
      end
      tick(1'b0, 32'h0, 1'b1, 1'b0);
    end
    tick(1'b1, 32'h1, 1'b0, 1'b0);
    wait_offer(idx, ok);
    checks++;
    if (!ok || idx !== 5'd0) begin
      errors++;
      $display("[TB] FAIL all_wrap_to_0: got ok=%0b idx=%0d, want ok=1 idx=0", ok, idx);
    end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic        r_sv, r_rdy, r_clr, r_rn;
    logic [31:0] r_vec;
    for (int i = 0; i < 400; i++) begin
      r_sv  = ($urandom_range(0, 1) == 1);
      r_vec = $urandom & $urandom & $urandom;
      r_rdy = ($urandom_range(0, 2) != 0);
      r_clr = ($urandom_range(0, 39) == 0);
      r_rn  = ($urandom_range(0, 99) != 0);
      tick(r_sv, r_vec, r_rdy, r_clr, r_rn);
      checks++;
      if (sel_vld !== m_off || pend_vec !== m_pend || pend_cnt !== 6'(m_cnt) || dup_err !== m_dup ||
          (m_off && sel_idx !== 5'(m_idx))) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: got vld=%0b idx=%0d pend=%h cnt=%0d dup=%0b, want vld=%0b idx=%0d pend=%h cnt=%0d dup=%0b",
                 i, sel_vld, sel_idx, pend_vec, pend_cnt, dup_err, m_off, m_idx, m_pend, m_cnt, m_dup);
      end
    end
  endtask

  // Run all scenarios in order, then report
  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    set_vld = 1'b0;
    set_vec = '0;
    sel_rdy = 1'b0;
    m_pend  = '0; m_ptr = 0; m_off = 0; m_idx = 0; m_dup = 0; m_cnt = 0;
    test_reset();
    test_two_bits();
    test_wrap();
    test_backpressure();
    test_collision();
    test_flush();
    test_all_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
